// File: rtl/sort_n_floats_pkg.sv
// Shared types and the FP ordering helper for the odd-even
// transposition sorter.
package sort_n_floats_pkg;

  localparam int FLEN  = 64;
  localparam int EXP_W = (FLEN == 32) ? 8 : 11;
  localparam int MAN_W = FLEN - 1 - EXP_W;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } sort_state_t;

  typedef logic [FLEN-1:0] flt_t;

  function automatic int phase_w(input int n);
    return $clog2(n);
  endfunction

  function automatic logic is_nan(input flt_t x);
    return (&x[FLEN-2:MAN_W]) & (|x[MAN_W-1:0]);
  endfunction

  // Returns {err, res}: res = (a <= b); a NaN operand gives err=1, res=0.
  function automatic logic [1:0] f_less_or_equal(
    input flt_t a,
    input flt_t b
  );
    logic [FLEN-2:0] ma;
    logic [FLEN-2:0] mb;
    logic            res;
    ma = a[FLEN-2:0];
    mb = b[FLEN-2:0];
    if (is_nan(a) | is_nan(b)) begin
      return 2'b10;
    end
    if ((ma == '0) && (mb == '0)) begin
      res = 1'b1;
    end else if (a[FLEN-1] != b[FLEN-1]) begin
      res = a[FLEN-1];
    end else if (!a[FLEN-1]) begin
      res = (ma <= mb);
    end else begin
      res = (ma >= mb);
    end
    return {1'b0, res};
  endfunction

endpackage

// File: rtl/sort_n_floats_seq_if.sv
// Valid/ready bundle between vector producer, sorter and consumer.
// master = producer/consumer side, slave = sorter side.
interface sort_n_floats_seq_if
  import sort_n_floats_pkg::*;
#(
  parameter int N = 8
);

  logic                      up_valid;
  logic                      up_ready;
  logic [0:N-1][FLEN-1:0]    unsorted;
  logic                      down_valid;
  logic                      down_ready;
  logic [0:N-1][FLEN-1:0]    sorted;
  logic                      err;

  modport master (
    output up_valid,
    output unsorted,
    output down_ready,
    input  up_ready,
    input  down_valid,
    input  sorted,
    input  err
  );

  modport slave (
    input  up_valid,
    input  unsorted,
    input  down_ready,
    output up_ready,
    output down_valid,
    output sorted,
    output err
  );

endinterface

// File: rtl/compare_exchange_floats.sv
// One compare-exchange slot: orders (a, b) into (lo, hi) unless a NaN
// is involved; equal values keep their order.
module compare_exchange_floats
  import sort_n_floats_pkg::*;
(
  input  logic en,
  input  flt_t a,
  input  flt_t b,
  output flt_t lo,
  output flt_t hi,
  output logic err
);

  logic [1:0] le;
  logic       swap;

  always_comb begin
    le   = f_less_or_equal(a, b);
    swap = en & ~le[1] & ~le[0];
    err  = en & le[1];
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/sort_n_floats_seq.sv
// Sequential odd-even transposition sorter: accepts an N-element vector,
// sorts it over N phases with a shared bank of floor(N/2) comparators.
module sort_n_floats_seq
  import sort_n_floats_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  sort_n_floats_seq_if.slave bus
);

  localparam int PW = phase_w(N);
  localparam int NP = N / 2;

  if (N < 2) begin : g_bad_n
    $error("sort_n_floats_seq: N must be at least 2");
  end

  sort_state_t        state_q;
  sort_state_t        state_d;
  logic [PW-1:0]      phase_q;
  logic [PW-1:0]      phase_d;
  flt_t [0:N-1]       data_q;
  flt_t [0:N-1]       data_d;
  logic               err_q;
  logic               err_d;

  flt_t               cx_a  [NP];
  flt_t               cx_b  [NP];
  flt_t               cx_lo [NP];
  flt_t               cx_hi [NP];
  logic [NP-1:0]      cx_en;
  logic [NP-1:0]      cx_err;

  // Slot k serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd
  // ones; the top slot idles on odd phases when N is even.
  for (genvar k = 0; k < NP; k++) begin : g_cx
    localparam bool_odd_ok = (2 * k + 2 < N);
    localparam int  EA     = 2 * k;
    localparam int  OA     = bool_odd_ok ? 2 * k + 1 : 2 * k;
    localparam int  OB     = bool_odd_ok ? 2 * k + 2 : 2 * k + 1;

    assign cx_a[k]  = phase_q[0] ? data_q[OA] : data_q[EA];
    assign cx_b[k]  = phase_q[0] ? data_q[OB] : data_q[EA+1];
    assign cx_en[k] = (state_q == SORT)
                    & (~phase_q[0] | 1'(bool_odd_ok));

    compare_exchange_floats u_cx (
      .en  (cx_en[k]),
      .a   (cx_a[k]),
      .b   (cx_b[k]),
      .lo  (cx_lo[k]),
      .hi  (cx_hi[k]),
      .err (cx_err[k])
    );
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.up_valid) begin
          state_d = SORT;
          phase_d = '0;
          data_d  = bus.unsorted;
          err_d   = 1'b0;
        end
      end
      SORT: begin
        for (int k = 0; k < NP; k++) begin
          if (!phase_q[0]) begin
            data_d[2*k]   = cx_lo[k];
            data_d[2*k+1] = cx_hi[k];
          end else if (2 * k + 2 < N) begin
            data_d[2*k+1] = cx_lo[k];
            data_d[2*k+2] = cx_hi[k];
          end
        end
        err_d = err_q | (|cx_err);
        if (phase_q == PW'(N - 1)) begin
          state_d = DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        if (bus.down_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.up_ready   = (state_q == IDLE);
  assign bus.down_valid = (state_q == DONE);
  assign bus.sorted     = data_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_sort_n_floats_seq.sv
// Directed and randomised bench for sort_n_floats_seq (N=8 and N=5),
// checked against a real-valued stable insertion-sort model.
module tb_sort_n_floats_seq;
  import sort_n_floats_pkg::*;

  localparam int N8 = 8;
  localparam int N5 = 5;
  localparam int WV = N8 * FLEN;

  typedef logic [FLEN-1:0] f_t;
  typedef logic [WV-1:0]   v_t;

  localparam f_t P1 = 64'h3FF0_0000_0000_0000;
  localparam f_t P2 = 64'h4000_0000_0000_0000;
  localparam f_t P3 = 64'h4008_0000_0000_0000;
  localparam f_t M1 = 64'hBFF0_0000_0000_0000;
  localparam f_t PZ = 64'h0000_0000_0000_0000;
  localparam f_t MZ = 64'h8000_0000_0000_0000;
  localparam f_t QN = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_n_floats_seq_if #(.N(N8)) bus8 ();
  sort_n_floats_seq_if #(.N(N5)) bus5 ();

  sort_n_floats_seq #(.N(N8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  sort_n_floats_seq #(.N(N5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit nan64(input f_t x);
    return (&x[62:52]) && (|x[51:0]);
  endfunction

  function automatic bit any_nan(input f_t v[$]);
    foreach (v[i]) begin
      if (nan64(v[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void ref_sort(input f_t v[$], output f_t s[$]);
    int j;
    s = {};
    foreach (v[i]) begin
      j = s.size();
      while (j > 0 && $bitstoreal(s[j-1]) > $bitstoreal(v[i])) j--;
      s.insert(j, v[i]);
    end
  endfunction

  function automatic v_t pack(input f_t v[$]);
    v_t r;
    r = '0;
    foreach (v[i]) r = (r << FLEN) | v_t'(v[i]);
    return r;
  endfunction

  function automatic f_t rnd_val();
    f_t pool [10];
    f_t x;
    pool = '{P1, P2, P3, M1, PZ, MZ,
             64'h3FE0_0000_0000_0000, 64'hC000_0000_0000_0000,
             64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0001};
    if ($urandom_range(1, 0) == 0) return pool[$urandom_range(9, 0)];
    x = {$urandom(), $urandom()};
    if (&x[62:52]) x[62] = 1'b0;
    return x;
  endfunction

  task automatic xfer8(input string tag, input f_t v[$], input int bp);
    f_t   s[$];
    bit   en;
    int   t0;
    v_t   hold;
    logic herr;
    ref_sort(v, s);
    en = any_nan(v);
    @(negedge clk);
    bus8.down_ready = 1'b0;
    bus8.unsorted   = pack(v);
    bus8.up_valid   = 1'b1;
    for (int i = 0; i < 20 && !bus8.up_ready; i++) @(negedge clk);
    chk({tag, "_uprdy"}, v_t'(bus8.up_ready), v_t'(1));
    t0 = cyc;
    @(negedge clk);
    bus8.up_valid = 1'b0;
    bus8.unsorted = '1;
    for (int i = 0; i < 40 && !bus8.down_valid; i++) @(negedge clk);
    chk({tag, "_lat"}, v_t'(cyc - t0), v_t'(N8 + 1));
    if (!en) chk({tag, "_sorted"}, v_t'(bus8.sorted), pack(s));
    chk({tag, "_err"}, v_t'(bus8.err), v_t'(en));
    hold = v_t'(bus8.sorted);
    herr = bus8.err;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, "_bp_sorted"}, v_t'(bus8.sorted), hold);
      chk({tag, "_bp_err"}, v_t'(bus8.err), v_t'(herr));
      chk({tag, "_bp_uprdy"}, v_t'(bus8.up_ready), v_t'(0));
      chk({tag, "_bp_dv"}, v_t'(bus8.down_valid), v_t'(1));
    end
    bus8.down_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_uprdy"}, v_t'(bus8.up_ready), v_t'(1));
    chk({tag, "_idle_dv"}, v_t'(bus8.down_valid), v_t'(0));
    bus8.down_ready = 1'b0;
  endtask

  task automatic xfer5(input string tag, input f_t v[$]);
    f_t s[$];
    v_t w;
    int t0;
    ref_sort(v, s);
    w = pack(v);
    @(negedge clk);
    bus5.down_ready = 1'b1;
    bus5.unsorted   = w[N5*FLEN-1:0];
    bus5.up_valid   = 1'b1;
    for (int i = 0; i < 20 && !bus5.up_ready; i++) @(negedge clk);
    chk({tag, "_uprdy"}, v_t'(bus5.up_ready), v_t'(1));
    t0 = cyc;
    @(negedge clk);
    bus5.up_valid = 1'b0;
    bus5.unsorted = '0;
    for (int i = 0; i < 40 && !bus5.down_valid; i++) @(negedge clk);
    chk({tag, "_lat"}, v_t'(cyc - t0), v_t'(N5 + 1));
    chk({tag, "_sorted"}, v_t'(bus5.sorted), pack(s));
    chk({tag, "_err"}, v_t'(bus5.err), v_t'(any_nan(v)));
    @(negedge clk);
    chk({tag, "_idle"}, v_t'(bus5.up_ready), v_t'(1));
  endtask

  task automatic run_random(input int nvec);
    f_t   v[$];
    f_t   s[$];
    v_t   exp_pend;
    v_t   exp_cur;
    v_t   hold;
    bit   nan_pend;
    bit   nan_cur;
    logic herr;
    bit   pend;
    bit   busy;
    bit   seen;
    bit   hv;
    int   sent;
    int   got;
    int   acc;
    exp_pend = '0;
    exp_cur  = '0;
    hold     = '0;
    nan_pend = 1'b0;
    nan_cur  = 1'b0;
    herr     = 1'b0;
    pend     = 1'b0;
    busy     = 1'b0;
    seen     = 1'b0;
    hv       = 1'b0;
    sent     = 0;
    got      = 0;
    acc      = 0;
    for (int it = 0; it < 60000 && got < nvec; it++) begin
      @(negedge clk);
      chk("rnd_uprdy", v_t'(bus8.up_ready), v_t'(!busy));
      chk("rnd_dv_idle", v_t'(bus8.down_valid & !busy), v_t'(0));
      if (bus8.down_valid) begin
        if (!seen) begin
          chk("rnd_lat", v_t'(cyc - acc), v_t'(N8 + 1));
          seen = 1'b1;
        end
        if (hv) begin
          chk("rnd_hold", v_t'(bus8.sorted), hold);
          chk("rnd_hold_err", v_t'(bus8.err), v_t'(herr));
        end
      end
      if (!pend && sent < nvec && $urandom_range(3, 0) != 0) begin
        v = {};
        for (int i = 0; i < N8; i++) v.push_back(rnd_val());
        if ($urandom_range(15, 0) == 0) v[$urandom_range(N8 - 1, 0)] = QN;
        ref_sort(v, s);
        exp_pend      = pack(s);
        nan_pend      = any_nan(v);
        bus8.unsorted = pack(v);
        bus8.up_valid = 1'b1;
        pend          = 1'b1;
        sent++;
      end else if (!pend) begin
        bus8.up_valid = 1'b0;
        bus8.unsorted = {16{$urandom()}};
      end
      bus8.down_ready = ($urandom_range(2, 0) != 0);
      if (bus8.up_valid && bus8.up_ready) begin
        acc     = cyc;
        busy    = 1'b1;
        pend    = 1'b0;
        seen    = 1'b0;
        exp_cur = exp_pend;
        nan_cur = nan_pend;
      end
      if (bus8.down_valid && bus8.down_ready) begin
        if (!nan_cur) chk("rnd_sorted", v_t'(bus8.sorted), exp_cur);
        chk("rnd_err", v_t'(bus8.err), v_t'(nan_cur));
        busy = 1'b0;
        hv   = 1'b0;
        got++;
      end else if (bus8.down_valid) begin
        hold = v_t'(bus8.sorted);
        herr = bus8.err;
        hv   = 1'b1;
      end
    end
    chk("rnd_count", v_t'(got), v_t'(nvec));
  endtask

  initial begin
    f_t v[$];
    bus8.up_valid   = 1'b0;
    bus8.down_ready = 1'b0;
    bus8.unsorted   = '0;
    bus5.up_valid   = 1'b0;
    bus5.down_ready = 1'b0;
    bus5.unsorted   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uprdy", v_t'(bus8.up_ready), v_t'(1));
    chk("rst_dv", v_t'(bus8.down_valid), v_t'(0));
    chk("rst_err", v_t'(bus8.err), v_t'(0));
    chk("rst_sorted", v_t'(bus8.sorted), v_t'(0));
    chk("rst5_uprdy", v_t'(bus5.up_ready), v_t'(1));
    rst = 1'b0;

    v = '{P3, P2, P1, M1, P3, P2, P1, M1};
    xfer8("basic", v, 0);
    v = '{P1, P2, QN, M1, P3, PZ, MZ, P1};
    xfer8("nan", v, 0);
    v = '{M1, P3, P1, P2, PZ, MZ, P2, M1};
    xfer8("bp", v, 10);

    v = '{P3, P3, P2, P2, P1, P1, M1, M1};
    @(negedge clk);
    bus8.unsorted = pack(v);
    bus8.up_valid = 1'b1;
    @(negedge clk);
    bus8.up_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_uprdy", v_t'(bus8.up_ready), v_t'(1));
    chk("midrst_dv", v_t'(bus8.down_valid), v_t'(0));
    chk("midrst_sorted", v_t'(bus8.sorted), v_t'(0));
    @(negedge clk);
    rst = 1'b0;
    v = '{P2, M1, P3, P1, MZ, P1, PZ, P3};
    xfer8("postrst", v, 0);

    v = '{P2, M1, P3, P1, M1};
    xfer5("odd5", v);
    v = '{PZ, P2, MZ, M1, P1};
    xfer5("stable5", v);
    v = '{P1, P2, QN, M1, P3};
    xfer5("nan5", v);

    run_random(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
